// File: rtl/fp_mul_round.sv
// Round / range-check / pack stage behind the fp_mul core: 2-cycle pipeline, one result per cycle.
// Define FP_MUL_ROUND_RNE_EN for round-to-nearest-even; the default build truncates.
module fp_mul_round (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        sign_i,
    input  logic [9:0]  exp_i,
    input  logic [47:0] man_i,
    input  logic        zero_i,
    input  logic        inf_i,
    input  logic        nan_i,
    output logic        done,
    output logic [31:0] res,
    output logic        overflow,
    output logic        underflow,
    output logic        exception
);

    // ---------------- stage 1: normalise and decide the round increment ----------------
    logic [22:0]        m_next;
    logic signed [9:0]  e_next;
    logic               inc_next;

    always_comb begin
        if (man_i[47]) begin
            m_next = man_i[46:24];
            e_next = $signed(exp_i) + 10'sd1;
        end else begin
            m_next = man_i[45:23];
            e_next = $signed(exp_i);
        end
    end

`ifdef FP_MUL_ROUND_RNE_EN
    logic g_next;
    logic s_next;

    always_comb begin
        if (man_i[47]) begin
            g_next = man_i[23];
            s_next = |man_i[22:0];
        end else begin
            g_next = man_i[22];
            s_next = |man_i[21:0];
        end
    end

    // Ties go to the even mantissa: a bare guard bit only rounds up an odd LSB.
    assign inc_next = g_next & (s_next | m_next[0]);
`else
    logic unused_low_bits;
    assign unused_low_bits = &{1'b0, man_i[23:0]};
    assign inc_next = 1'b0;
`endif

    logic               valid1_reg;
    logic [22:0]        m1_reg;
    logic signed [9:0]  e1_reg;
    logic               inc1_reg;
    logic               sign1_reg;
    logic               zero1_reg;
    logic               inf1_reg;
    logic               nan1_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid1_reg <= 1'b0;
            m1_reg     <= '0;
            e1_reg     <= '0;
            inc1_reg   <= 1'b0;
            sign1_reg  <= 1'b0;
            zero1_reg  <= 1'b0;
            inf1_reg   <= 1'b0;
            nan1_reg   <= 1'b0;
        end else begin
            valid1_reg <= start;
            if (start) begin
                m1_reg    <= m_next;
                e1_reg    <= e_next;
                inc1_reg  <= inc_next;
                sign1_reg <= sign_i;
                zero1_reg <= zero_i;
                inf1_reg  <= inf_i;
                nan1_reg  <= nan_i;
            end
        end
    end

    // ---------------- stage 2: apply rounding, range-check, pack ----------------
    logic [22:0]        mr_next;
    logic signed [9:0]  e2_next;

`ifdef FP_MUL_ROUND_RNE_EN
    logic [23:0] sum_next;
    assign sum_next = {1'b0, m1_reg} + {23'd0, inc1_reg};

    // A carry out of the mantissa means 1.111..1 rounded up to 10.000..0.
    always_comb begin
        if (sum_next[23]) begin
            mr_next = '0;
            e2_next = e1_reg + 10'sd1;
        end else begin
            mr_next = sum_next[22:0];
            e2_next = e1_reg;
        end
    end
`else
    logic unused_inc;
    assign unused_inc = inc1_reg;
    assign mr_next    = m1_reg;
    assign e2_next    = e1_reg;
`endif

    logic [31:0] res_next;
    logic        ovf_next;
    logic        unf_next;
    logic        exc_next;

    always_comb begin
        res_next = {sign1_reg, e2_next[7:0], mr_next};
        ovf_next = 1'b0;
        unf_next = 1'b0;
        exc_next = 1'b0;
        if (nan1_reg || (inf1_reg && zero1_reg)) begin
            res_next = 32'h7FC0_0000;
            exc_next = 1'b1;
        end else if (inf1_reg) begin
            res_next = {sign1_reg, 8'hFF, 23'd0};
        end else if (zero1_reg) begin
            res_next = {sign1_reg, 31'd0};
        end else if (e2_next >= 10'sd255) begin
            res_next = {sign1_reg, 8'hFF, 23'd0};
            ovf_next = 1'b1;
        end else if (e2_next <= 10'sd0) begin
            res_next = {sign1_reg, 31'd0};
            unf_next = 1'b1;
        end
    end

    logic        done_reg;
    logic [31:0] res_reg;
    logic        ovf_reg;
    logic        unf_reg;
    logic        exc_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            done_reg <= 1'b0;
            res_reg  <= '0;
            ovf_reg  <= 1'b0;
            unf_reg  <= 1'b0;
            exc_reg  <= 1'b0;
        end else begin
            done_reg <= valid1_reg;
            if (valid1_reg) begin
                res_reg <= res_next;
                ovf_reg <= ovf_next;
                unf_reg <= unf_next;
                exc_reg <= exc_next;
            end
        end
    end

    assign done      = done_reg;
    assign res       = res_reg;
    assign overflow  = ovf_reg;
    assign underflow = unf_reg;
    assign exception = exc_reg;

endmodule

// File: tb/tb_fp_mul_round.sv
// Self-checking bench for fp_mul_round: directed cases plus random products against a numeric reference model.
// Follows FP_MUL_ROUND_RNE_EN the same way the design does.
module tb_fp_mul_round;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        sign_i = 1'b0;
    logic [9:0]  exp_i = '0;
    logic [47:0] man_i = '0;
    logic        zero_i = 1'b0;
    logic        inf_i = 1'b0;
    logic        nan_i = 1'b0;
    logic        done;
    logic [31:0] res;
    logic        overflow;
    logic        underflow;
    logic        exception;

    fp_mul_round dut (
        .clk(clk), .rst(rst), .start(start), .sign_i(sign_i), .exp_i(exp_i),
        .man_i(man_i), .zero_i(zero_i), .inf_i(inf_i), .nan_i(nan_i),
        .done(done), .res(res), .overflow(overflow), .underflow(underflow),
        .exception(exception)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle = cycle + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, got, want, cycle);
    endtask

    typedef struct {
        int          due;
        logic [31:0] res;
        logic        ov;
        logic        un;
        logic        ex;
    } exp_t;
    exp_t q[$];

    // Reference: treat the mantissa as an integer, round by remainder against half an ulp.
    function automatic logic [34:0] model(bit s, int e, logic [47:0] man, bit z, bit inf, bit nan);
        longint unsigned mfull, rem, half, mask;
        int sh;
        logic [7:0] e8;
        logic [22:0] frac;
        if (nan || (inf && z)) return {32'h7FC00000, 3'b001};
        if (inf) return {s, 8'hFF, 23'd0, 3'b000};
        if (z)   return {s, 31'd0, 3'b000};
        sh    = man[47] ? 24 : 23;
        e     = e + (man[47] ? 1 : 0);
        mfull = 64'(man) >> sh;
        mask  = (64'd1 << sh) - 64'd1;
        rem   = 64'(man) & mask;
        half  = 64'd1 << (sh - 1);
`ifdef FP_MUL_ROUND_RNE_EN
        if (rem > half || (rem == half && (mfull % 2) == 1)) mfull = mfull + 1;
`else
        if (rem > half) mfull = mfull + 0;
`endif
        if (mfull == (64'd1 << 24)) begin
            mfull = mfull >> 1;
            e = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'd0, 3'b100};
        if (e <= 0)   return {s, 31'd0, 3'b010};
        e8   = e[7:0];
        frac = mfull[22:0];
        return {s, e8, frac, 3'b000};
    endfunction

    task automatic issue(input bit s, input int e, input logic [47:0] man,
                         input bit z, input bit inf, input bit nan, input logic [34:0] want);
        exp_t x;
        sign_i = s; exp_i = e[9:0]; man_i = man;
        zero_i = z; inf_i = inf; nan_i = nan;
        start = 1'b1;
        x.due = cycle + 2;
        x.res = want[34:3]; x.ov = want[2]; x.un = want[1]; x.ex = want[0];
        q.push_back(x);
        $display("issue: s=%0d e=%0d man=%012h z=%0d i=%0d n=%0d -> res=%08h ov/un/ex=%0d%0d%0d",
                 s, e, man, z, inf, nan, x.res, x.ov, x.un, x.ex);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            start  = 1'b0;
            exp_i  = 10'($urandom);
            man_i  = {$urandom, $urandom};
            sign_i = 1'($urandom); zero_i = 1'($urandom); inf_i = 1'($urandom); nan_i = 1'($urandom);
            @(posedge clk); #1;
        end
    endtask

    // Scoreboard: every cycle, done must match the queue; on done, result and flags too.
    always @(negedge clk) begin
        if (!rst) begin
            logic want_done;
            want_done = (q.size() > 0) && (q[0].due == cycle);
            check("done", {31'd0, done}, {31'd0, want_done});
            if (want_done) begin
                check("res", res, q[0].res);
                check("flags", {29'd0, overflow, underflow, exception}, {29'd0, q[0].ov, q[0].un, q[0].ex});
                q.pop_front();
            end else if (q.size() > 0 && q[0].due < cycle) begin
                check("lost", 32'd0, 32'd1);
                q.pop_front();
            end
        end
    end

    initial begin
        logic [23:0] ma, mb;
        logic [47:0] man;
        int e;
        bit s, z, inf, nan;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_res", res, 32'd0);
        check("rst_flags", {28'd0, done, overflow, underflow, exception}, 32'd0);
        idle(2);

        issue(0, 128, 48'h600000000000, 0, 0, 0, {32'h40400000, 3'b000});
        idle(2);
`ifdef FP_MUL_ROUND_RNE_EN
        issue(0, 127, 48'h7FFFFFC00000, 0, 0, 0, {32'h40000000, 3'b000});
`else
        issue(0, 127, 48'h7FFFFFC00000, 0, 0, 0, {32'h3FFFFFFF, 3'b000});
`endif
        issue(0, 127, 48'h400000400000, 0, 0, 0, {32'h3F800000, 3'b000});
        issue(1, 254, 48'h800000000000, 0, 0, 0, {32'hFF800000, 3'b100});
        issue(0, -7,  48'h400000000000, 0, 0, 0, {32'h00000000, 3'b010});
        issue(0, 100, 48'h400000000000, 0, 0, 1, {32'h7FC00000, 3'b001});
        issue(1, 100, 48'h400000000000, 1, 1, 0, {32'h7FC00000, 3'b001});
        issue(1, 100, 48'h400000000000, 0, 1, 0, {32'hFF800000, 3'b000});
        issue(1, 100, 48'h400000000000, 1, 0, 0, {32'h80000000, 3'b000});
        idle(3);

        // Random products of two normal significands, with occasional idle gaps and special classes.
        for (int i = 0; i < 300; i++) begin
            ma  = {1'b1, 23'($urandom)};
            mb  = {1'b1, 23'($urandom)};
            if (i % 7 == 0) mb = 24'h800000;
            man = 48'(ma) * 48'(mb);
            e   = $urandom_range(0, 510) - 127;
            if (i % 5 == 0) e = $urandom_range(0, 6) - 3;
            if (i % 5 == 1) e = $urandom_range(250, 256);
            s   = 1'($urandom);
            z   = ($urandom_range(0, 15) == 0);
            inf = ($urandom_range(0, 15) == 0);
            nan = ($urandom_range(0, 15) == 0);
            issue(s, e, man, z, inf, nan, model(s, e, man, z, inf, nan));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        idle(3);

        // Reset one cycle after a start: the beat must vanish and outputs clear.
        issue(0, 130, 48'h600000000000, 0, 0, 0, {32'h41400000, 3'b000});
        start = 1'b0;
        rst = 1'b1;
        q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("rst_mid_res", res, 32'd0);
        check("rst_mid_flags", {29'd0, overflow, underflow, exception}, 32'd0);
        idle(4);

        // rst together with start drops the beat.
        sign_i = 0; exp_i = 10'd130; man_i = 48'h600000000000;
        zero_i = 0; inf_i = 0; nan_i = 0;
        start = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        rst = 1'b0;
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fp_mul_round.md
# fp_mul_round

Rounding, range-check and packing stage that sits directly downstream of the `fp_mul` datapath core. It consumes the raw product: sign, unnormalised biased exponent sum and 48-bit mantissa product, plus operand-class flags from the unpack logic. It produces a packed IEEE-754 single-precision result with overflow, underflow and exception flags. The stage is a 2-cycle, fully pipelined block with one result per cycle and a `start`/`done` pulse handshake.

## Interface
- No parameters.
- `clk` input 1 — clock.
- `rst` input 1 — reset, synchronous, active-high.
- `start` input 1 — input beat valid; one-cycle pulse per operation; back-to-back pulses allowed.
- `sign_i` input 1 — product sign (`sa ^ sb`).
- `exp_i` input 10 — biased exponent sum `ea + eb - 127`, two's complement; valid range -127..383.
- `man_i` input 48 — `{1,ma} * {1,mb}` raw product.
- `zero_i` input 1 — either operand is zero.
- `inf_i` input 1 — either operand is infinite.
- `nan_i` input 1 — either operand is NaN.
- `done` output 1 — result valid pulse; reset 0.
- `res` output 32 — packed result; reset 0.
- `overflow` output 1 — reset 0.
- `underflow` output 1 — reset 0.
- `exception` output 1 — reset 0.

## Operation
- Stage 1 (registered when `start`=1):
  - Normalise. If `man_i[47]`: `m = man_i[46:24]`, `g = man_i[23]`, `s = |man_i[22:0]`, `e = exp_i + 1`.
  - Otherwise: `m = man_i[45:23]`, `g = man_i[22]`, `s = |man_i[21:0]`, `e = exp_i`.
  - Round increment: `inc = g & (s | m[0])` (round to nearest, ties to even).
  - Register `m`, `e`, `inc`, sign and class flags.
- Stage 2 (registered):
  - `{c, mr} = {1'b0, m} + inc` (24-bit). If `c`: `mr = 0`, `e = e + 1`. All exponent arithmetic is 10-bit signed.
  - Output select, highest priority first:
    - `nan_i`, or `inf_i & zero_i` → `res = 32'h7FC00000`, `exception = 1`.
    - `inf_i` → `{sign, 8'hFF, 23'd0}`, no flags.
    - `zero_i` → `{sign, 31'd0}`, no flags.
    - `e >= 255` → `{sign, 8'hFF, 23'd0}`, `overflow = 1`.
    - `e <= 0` → `{sign, 31'd0}`, `underflow = 1` (flush to zero, no subnormals).
    - Otherwise → `{sign, e[7:0], mr}`.
- Flags are mutually exclusive per result.
- `res` and flags update only on a stage-2 valid beat and hold their value otherwise.

## Timing
- Latency is 2: `start` at cycle N gives `done`=1 at cycle N+2, with `res` and flags valid in the same cycle.
- Throughput is 1 per cycle. No backpressure; the consumer must accept on `done`.
- `done` is a single-cycle pulse per `start`. Consecutive starts give consecutive dones, in order.
- Inputs are sampled only on cycles where `start`=1. The stage ignores inputs otherwise.
- Reset mid-operation: all in-flight beats are squashed. `done` is 0 for at least the 2 cycles after reset deasserts, unless a new `start` arrives. Outputs read 0 until the first `done`.
- If `rst` and `start` are asserted together, `rst` wins and the beat is dropped.

## Configuration
- `FP_MUL_ROUND_RNE_EN`
- Defined: round-to-nearest-even as described above, including mantissa carry-out and the exponent bump.
- Undefined: truncation. `inc` is tied to 0, guard/sticky logic is removed, and there is no carry path. Latency is unchanged (still 2).

## Test plan
- 1.5×2.0 (`exp_i=128`, `man_i=48'h600000000000`, class flags 0) → `done` 2 cycles after `start`, `res=32'h40400000`, all flags 0.
- Round carry (`exp_i=127`, `man_i=48'h7FFFFFC00000`) → `res=32'h40000000` with `FP_MUL_ROUND_RNE_EN`; `res=32'h3FFFFFFF` without it.
- Tie to even (`exp_i=127`, `man_i=48'h400000400000`) → `res=32'h3F800000`, no increment.
- Overflow (`exp_i=254`, `man_i=48'h800000000000`, `sign_i=1`) → `res=32'hFF800000`, `overflow=1`. Underflow (`exp_i=-7`, `man_i=48'h400000000000`) → `res=32'h00000000`, `underflow=1`.
- Specials: `nan_i=1` → `res=32'h7FC00000`, `exception=1`; `inf_i=zero_i=1` → same; `inf_i=1`, `sign_i=1` → `res=32'hFF800000`, no flags.
- Stream and reset:
  - Four back-to-back starts with distinct operands → four consecutive `done` pulses with in-order results.
  - `rst` asserted 1 cycle after a `start` → no `done`, and outputs are 0.
